gmii_tx_framer: RTL and testbench
=================================

// Module: gmii_tx_framer
// PURPOSE
//  Downstream of the frame senders (ARP etc.): takes their byte stream (in_en/in_data/in_av, fin as in_last),
//  buffers it in a FIFO, prepends 7x8'h55 + 8'hD5 and drives GMII TX, enforcing a 12-byte inter-frame gap.
//  Senders supply complete frames incl. padding and FCS; this block adds only preamble/SFD.
// PARAMETERS
//  FIFO_DEPTH   2048  byte entries (power of 2); each entry = {last, data[7:0]}
//  AV_MARGIN    2     in_av low once free entries <= AV_MARGIN (sender reacts one cycle late)
//  START_THRESH 1024  occupancy that starts a frame before its last byte is stored (cut-through)
//  IFG_BYTES    12    idle cycles between frames
// PORTS
//  clk         in   1  GMII TX clock (125 MHz)
//  clr         in   1  asynchronous, active-high reset
//  in_en       in   1  byte valid from sender
//  in_data     in   8  byte from sender
//  in_last     in   1  last byte of frame; same cycle as final in_en (sender fin)
//  in_av       out  1  space available; sender may issue in_en on the following cycle
//  gmii_txd    out  8  TX data
//  gmii_tx_en  out  1  TX enable
//  gmii_tx_er  out  1  TX error (underrun)
//  tx_busy     out  1  FSM not IDLE
//  frame_done  out  1  1-cycle pulse after last data byte leaves
//  underrun    out  1  1-cycle pulse when FIFO empties mid-frame
// BEHAVIOUR
//  Reset: clk and clr only; clr async active-high. All outputs 0 except in_av=1; FIFO empty, frame_cnt=0, FSM IDLE.
//  Write: in_en pushes {in_last,in_data}; in_en while full is dropped (protocol violation, assert in sim).
//  in_av = (FIFO_DEPTH - occupancy) > AV_MARGIN, combinational from registered counters.
//  frame_cnt: +1 on write with last, -1 on read of entry with last; both same cycle -> unchanged.
//  FSM (all GMII outputs registered; ready = frame_cnt!=0 || occupancy>=START_THRESH):
//   IDLE: ready -> PREAMBLE; next cycle txd=55, tx_en=1.
//   PREAMBLE: 7 cycles txd=55 -> SFD: 1 cycle txd=D5 -> DATA.
//   DATA: pop FIFO (first-word-fall-through) every cycle, txd=entry data;
//         popped entry has last -> IFG, frame_done pulses the cycle tx_en falls.
//         FIFO empty in DATA -> underrun pulse, tx_er=1, tx_en=1, txd=0; state UNDERRUN.
//   UNDERRUN: tx_en=tx_er=1, discard entries until one with last is popped (one cycle after it arrives if empty);
//            then IFG. No frame_done for the aborted frame.
//   IFG: tx_en=0, txd=0 for IFG_BYTES cycles (counter 0..IFG_BYTES-1), then IDLE; IDLE may start same cycle as entry.
//  Frame on wire: 8 + N bytes with tx_en=1, >= IFG_BYTES idle before next preamble.
//  Writes proceed in every state; a read and a write in the same cycle at full/empty are both honoured.
//  Pointers log2(FIFO_DEPTH) bits, wrap naturally; occupancy log2(FIFO_DEPTH)+1 bits.
//  clr mid-frame: tx_en drops immediately (async), FIFO contents lost.
// STRUCTURE
//  Shared package (eth_pkg): PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, PREAMBLE_LEN=7, IFG default, FSM state enum.
//  One sub-module: sync_fifo_fwft (WIDTH=9, DEPTH=FIFO_DEPTH, count output, async clr). FSM/counters stay here.
// TESTING
//  1 64-byte ARP frame (FF..FF first, FCS last) with last -> tx_en high 72 cycles: 7x55, D5, 64 bytes in order.
//  2 Two frames back-to-back, second already buffered -> exactly 12 cycles tx_en=0 between them.
//  3 Hold reads off (frame > FIFO w/o last, START_THRESH raised) -> in_av low at occupancy FIFO_DEPTH-2, none lost.
//  4 Cut-through: 1024 bytes queued, sender stalls 20 cycles -> underrun pulse, tx_er=1 until last popped, no frame_done.
//  5 clr asserted during DATA byte 30 -> outputs 0 without clock edge; next 60-byte frame sent cleanly.
//  6 Write of last byte frame B same cycle as read of last byte frame A -> frame_cnt stays 1, B starts after IFG.

Source files
------------

// File: rtl/gmii_tx_framer_pkg.sv
// Shared constants and FSM state type for the GMII transmit framer.
package gmii_tx_framer_pkg;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE = 8'hD5;
    localparam int unsigned PREAMBLE_LEN = 7;
    localparam int unsigned IFG_BYTES_DEFAULT = 12;

    typedef enum logic [2:0] {
        StIdle,
        StPreamble,
        StSfd,
        StData,
        StUnderrun,
        StIfg
    } tx_state_e;

endpackage

// File: rtl/gmii_tx_framer_if.sv
// Byte-stream handshake between a frame sender and the GMII transmit framer.
interface gmii_tx_framer_if;

    logic       in_en;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_av;

    modport master (output in_en, output in_data, output in_last, input in_av);
    modport slave (input in_en, input in_data, input in_last, output in_av);

endinterface

// File: rtl/gmii_tx_framer_sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO with occupancy count and async clear.
module sync_fifo_fwft #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 2048
) (
    input  logic                     clk_i,
    input  logic                     clr_i,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     empty_o,
    output logic                     wr_ok_o,
    output logic                     rd_ok_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             full;

    assign empty_o = (count_q == '0);
    assign full    = (count_q == (AW + 1)'(DEPTH));
    assign rd_ok_o = rd_en_i && !empty_o;
    // A pop in the same cycle frees the slot, so a write at full is still taken.
    assign wr_ok_o = wr_en_i && (!full || rd_ok_o);

    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok_o) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_ok_o) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (AW + 1)'(wr_ok_o) - (AW + 1)'(rd_ok_o);
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok_o) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

endmodule

// File: rtl/gmii_tx_framer.sv
// Buffers sender frames, prepends preamble/SFD, drives GMII TX and enforces the inter-frame gap.
module gmii_tx_framer
    import gmii_tx_framer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 2048,
    parameter int unsigned AV_MARGIN    = 2,
    parameter int unsigned START_THRESH = 1024,
    parameter int unsigned IFG_BYTES    = IFG_BYTES_DEFAULT
) (
    input  logic              clk_i,
    input  logic              clr_i,
    gmii_tx_framer_if.slave   in_if,
    output logic [7:0]        gmii_txd_o,
    output logic              gmii_tx_en_o,
    output logic              gmii_tx_er_o,
    output logic              tx_busy_o,
    output logic              frame_done_o,
    output logic              underrun_o
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [8:0]    rd_data;
    logic          empty, wr_ok, rd_ok, rd_en;
    logic [CW-1:0] count;
    logic [CW-1:0] frame_cnt_q, frame_cnt_d;
    logic          push_last, pop_last, ready;

    tx_state_e  state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] txd_q, txd_d;
    logic       en_q, en_d, er_q, er_d, done_q, done_d, urun_q, urun_d;
    logic       abort_q, abort_d;

    sync_fifo_fwft #(
        .WIDTH (9),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .clr_i     (clr_i),
        .wr_en_i   (in_if.in_en),
        .wr_data_i ({in_if.in_last, in_if.in_data}),
        .rd_en_i   (rd_en),
        .rd_data_o (rd_data),
        .empty_o   (empty),
        .wr_ok_o   (wr_ok),
        .rd_ok_o   (rd_ok),
        .count_o   (count)
    );

    assign in_if.in_av = (FIFO_DEPTH - 32'(count)) > AV_MARGIN;

    assign push_last = wr_ok && in_if.in_last;
    assign pop_last  = rd_ok && rd_data[8];
    assign ready     = (frame_cnt_q != '0) || (32'(count) >= START_THRESH);

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (push_last && !pop_last) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
        end else if (!push_last && pop_last) begin
            frame_cnt_d = frame_cnt_q - 1'b1;
        end
    end

    // Outputs computed here appear on the wire one cycle later.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        txd_d   = 8'h00;
        en_d    = 1'b0;
        er_d    = 1'b0;
        done_d  = 1'b0;
        urun_d  = 1'b0;
        abort_d = abort_q;
        rd_en   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ready) begin
                    state_d = StPreamble;
                    cnt_d   = '0;
                    txd_d   = PREAMBLE_BYTE;
                    en_d    = 1'b1;
                    abort_d = 1'b0;
                end
            end
            StPreamble: begin
                txd_d = PREAMBLE_BYTE;
                en_d  = 1'b1;
                if (cnt_q == 8'(PREAMBLE_LEN - 2)) begin
                    state_d = StSfd;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StSfd: begin
                txd_d   = SFD_BYTE;
                en_d    = 1'b1;
                state_d = StData;
            end
            StData: begin
                en_d  = 1'b1;
                rd_en = 1'b1;
                if (empty) begin
                    er_d    = 1'b1;
                    urun_d  = 1'b1;
                    abort_d = 1'b1;
                    state_d = StUnderrun;
                end else begin
                    txd_d = rd_data[7:0];
                    if (rd_data[8]) begin
                        state_d = StIfg;
                        cnt_d   = '0;
                    end
                end
            end
            StUnderrun: begin
                en_d  = 1'b1;
                er_d  = 1'b1;
                rd_en = 1'b1;
                if (pop_last) begin
                    state_d = StIfg;
                    cnt_d   = '0;
                end
            end
            StIfg: begin
                done_d = (cnt_q == '0) && !abort_q;
                if (cnt_q == 8'(IFG_BYTES - 1)) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            txd_q       <= '0;
            en_q        <= 1'b0;
            er_q        <= 1'b0;
            done_q      <= 1'b0;
            urun_q      <= 1'b0;
            abort_q     <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            txd_q       <= txd_d;
            en_q        <= en_d;
            er_q        <= er_d;
            done_q      <= done_d;
            urun_q      <= urun_d;
            abort_q     <= abort_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign gmii_txd_o   = txd_q;
    assign gmii_tx_en_o = en_q;
    assign gmii_tx_er_o = er_q;
    assign tx_busy_o    = (state_q != StIdle);
    assign frame_done_o = done_q;
    assign underrun_o   = urun_q;

    // Senders must respect in_av; a write into a full FIFO is dropped.
    assert property (@(posedge clk_i) disable iff (clr_i) in_if.in_en |-> wr_ok);

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Directed self-checking bench for gmii_tx_framer: framing, IFG, flow control, underrun, clear.
module tb_gmii_tx_framer;
    import gmii_tx_framer_pkg::*;

    logic clk = 1'b0;
    logic clr = 1'b0;
    always #4 clk = ~clk;

    gmii_tx_framer_if bus ();
    gmii_tx_framer_if bus2 ();

    logic [7:0] txd, txd2;
    logic       en, er, busy, done, urun;
    logic       en2, er2, busy2, done2, urun2;

    gmii_tx_framer #(
        .FIFO_DEPTH   (2048),
        .AV_MARGIN    (2),
        .START_THRESH (1024),
        .IFG_BYTES    (12)
    ) dut (
        .clk_i        (clk),
        .clr_i        (clr),
        .in_if        (bus.slave),
        .gmii_txd_o   (txd),
        .gmii_tx_en_o (en),
        .gmii_tx_er_o (er),
        .tx_busy_o    (busy),
        .frame_done_o (done),
        .underrun_o   (urun)
    );

    // Small FIFO with an unreachable start threshold: reads held off until a last byte.
    gmii_tx_framer #(
        .FIFO_DEPTH   (16),
        .AV_MARGIN    (2),
        .START_THRESH (64),
        .IFG_BYTES    (12)
    ) dut2 (
        .clk_i        (clk),
        .clr_i        (clr),
        .in_if        (bus2.slave),
        .gmii_txd_o   (txd2),
        .gmii_tx_en_o (en2),
        .gmii_tx_er_o (er2),
        .tx_busy_o    (busy2),
        .frame_done_o (done2),
        .underrun_o   (urun2)
    );

    int checks = 0;
    int fails = 0;

    logic [8:0] wq[$];
    logic [8:0] wq2[$];
    int done_cnt = 0, urun_cnt = 0, gap_cnt = 0, last_gap = -1;

    always @(negedge clk) begin
        if (en === 1'b1) begin
            if (gap_cnt > 0) last_gap = gap_cnt;
            gap_cnt = 0;
            wq.push_back({er, txd});
        end else begin
            gap_cnt++;
        end
        if (done === 1'b1) done_cnt++;
        if (urun === 1'b1) urun_cnt++;
        if (en2 === 1'b1) wq2.push_back({er2, txd2});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] fb(input int f, input int i);
        if (f == 1 && i < 6) return 8'hFF;
        return 8'(f * 37 + i * 5 + 1);
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int f, input int n, input bit with_last);
        for (int i = 0; i < n; i++) begin
            bus.in_en   = 1'b1;
            bus.in_data = fb(f, i);
            bus.in_last = with_last && (i == n - 1);
            cyc(1);
        end
        bus.in_en   = 1'b0;
        bus.in_last = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int target, input int bound);
        int k = 0;
        while (done_cnt < target && k < bound) begin
            @(negedge clk);
            k++;
        end
        chk(tag, done_cnt, target);
    endtask

    task automatic check_frame(input string tag, input logic [8:0] q[$], input int f, input int n,
                               input int base);
        int bad = 0;
        if (q.size() < base + 8 + n) begin
            bad = n + 8;
        end else begin
            for (int j = 0; j < 7; j++) if (q[base + j] !== {1'b0, PREAMBLE_BYTE}) bad++;
            if (q[base + 7] !== {1'b0, SFD_BYTE}) bad++;
            for (int i = 0; i < n; i++) if (q[base + 8 + i] !== {1'b0, fb(f, i)}) bad++;
        end
        chk(tag, bad, 0);
    endtask

    initial begin
        int d0, u0, k, seen, tail_er;
        bus.in_en = 1'b0;  bus.in_data = '0;  bus.in_last = 1'b0;
        bus2.in_en = 1'b0; bus2.in_data = '0; bus2.in_last = 1'b0;
        #1 clr = 1'b1;
        #2;
        chk("rst_tx_en", 32'(en), 0);
        chk("rst_txd", 32'(txd), 0);
        chk("rst_tx_er", 32'(er), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done_urun", {30'd0, done, urun}, 0);
        chk("rst_in_av", 32'(bus.in_av), 1);
        cyc(2);
        clr = 1'b0;
        cyc(2);

        // Flow control on the 16-entry instance.
        seen = 0;
        for (int i = 0; i < 14; i++) begin
            if (bus2.in_av === 1'b1) seen++;
            bus2.in_en   = 1'b1;
            bus2.in_data = fb(10, i);
            bus2.in_last = 1'b0;
            cyc(1);
        end
        bus2.in_en = 1'b0;
        chk("t3_av_high_below_14", seen, 14);
        chk("t3_av_low_at_14", 32'(bus2.in_av), 0);
        chk("t3_no_tx_yet", 32'(en2), 0);
        bus2.in_en   = 1'b1;
        bus2.in_data = fb(10, 14);
        bus2.in_last = 1'b1;
        cyc(1);
        bus2.in_en   = 1'b0;
        bus2.in_last = 1'b0;
        k = 0;
        while (wq2.size() < 23 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_frame("t3_frame_intact", wq2, 10, 15, 0);
        cyc(20);
        chk("t3_av_recovers", 32'(bus2.in_av), 1);
        chk("t3_len", wq2.size(), 23);

        // 64-byte ARP frame.
        wq.delete();
        send(1, 64, 1'b1);
        wait_done("t1_done", 1, 300);
        chk("t1_len", wq.size(), 72);
        check_frame("t1_frame", wq, 1, 64, 0);
        chk("t1_no_underrun", urun_cnt, 0);
        cyc(20);

        // Back-to-back frames.
        wq.delete();
        d0 = done_cnt;
        send(2, 64, 1'b1);
        send(3, 64, 1'b1);
        wait_done("t2_done", d0 + 2, 400);
        chk("t2_len", wq.size(), 144);
        check_frame("t2_frame_a", wq, 2, 64, 0);
        check_frame("t2_frame_b", wq, 3, 64, 72);
        chk("t2_gap", last_gap, 12);
        cyc(20);

        // Last byte of B written in the cycle A's last byte is popped.
        wq.delete();
        d0 = done_cnt;
        send(8, 20, 1'b1);
        cyc(18);
        send(9, 10, 1'b1);
        wait_done("t6_done", d0 + 2, 300);
        check_frame("t6_frame_a", wq, 8, 20, 0);
        check_frame("t6_frame_b", wq, 9, 10, 28);
        chk("t6_gap", last_gap, 12);
        cyc(20);

        // Cut-through then underrun.
        wq.delete();
        d0 = done_cnt;
        u0 = urun_cnt;
        send(4, 1024, 1'b0);
        k = 0;
        while (urun_cnt == u0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("t4_underrun_pulse", urun_cnt, u0 + 1);
        cyc(20);
        send(7, 3, 1'b1);
        k = 0;
        while (busy !== 1'b0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("t4_back_idle", 32'(busy), 0);
        check_frame("t4_good_part", wq, 4, 1024, 0);
        tail_er = 0;
        for (int i = 1032; i < wq.size(); i++) if (wq[i] === {1'b1, 8'h00}) tail_er++;
        chk("t4_tail_all_er", tail_er, wq.size() - 1032);
        chk("t4_tail_long", 32'(wq.size() >= 1032 + 21), 1);
        cyc(20);
        chk("t4_no_done", done_cnt, d0);
        chk("t4_single_underrun", urun_cnt, u0 + 1);

        // Asynchronous clear during data byte 30.
        wq.delete();
        d0 = done_cnt;
        send(5, 64, 1'b1);
        k = 0;
        while (wq.size() < 39 && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("t5_reached_byte30", 32'(wq.size() >= 39), 1);
        #1 clr = 1'b1;
        #1;
        chk("t5_clr_tx_en", 32'(en), 0);
        chk("t5_clr_txd", 32'(txd), 0);
        chk("t5_clr_busy", 32'(busy), 0);
        chk("t5_clr_in_av", 32'(bus.in_av), 1);
        @(posedge clk);
        #1 clr = 1'b0;
        cyc(5);
        chk("t5_no_done_aborted", done_cnt, d0);
        wq.delete();
        send(6, 60, 1'b1);
        wait_done("t5_done_next", d0 + 1, 300);
        chk("t5_len_next", wq.size(), 68);
        check_frame("t5_frame_next", wq, 6, 60, 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
